// File: rtl/oled_burst_writer.sv
`timescale 1ns/1ps
// oled_burst_writer: page/column addressing plus streamed data bytes to an SPI byte transmitter
module oled_burst_writer #(
  parameter int COLS = 128,
  parameter int PAGES = 8,
  parameter int COL_OFFSET = 0,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_start,
  input  logic [7:0]       set_pos_x,
  input  logic [7:0]       set_pos_y,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             send_done,
  output logic             spi_send,
  output logic [7:0]       spi_data,
  output logic             dc,
  output logic             busy,
  output logic             write_done,
  output logic             pos_err
);
  typedef enum logic [2:0] {IDLE, CMD_PAGE, CMD_COLH, CMD_COLL, DATA_WAIT, DATA_SEND, GAP, DONE} state_t;
  localparam logic [8:0] cols_w = 9'(COLS);
  localparam logic [7:0] last_col = 8'(COLS - 1);
  localparam logic [7:0] last_page = 8'(PAGES - 1);
  localparam logic [7:0] col_off = 8'(COL_OFFSET);
  state_t state, state_n, ret, ret_n;
  logic [7:0] col, col_n, page, page_n, data_q, data_n, cv;
  logic [LEN_W-1:0] rem, rem_n;
  logic err, err_n, sending;
  always_comb begin
    state_n = state;
    ret_n = ret;
    col_n = col;
    page_n = page;
    rem_n = rem;
    data_n = data_q;
    err_n = err;
    case (state)
      IDLE: if (write_start) begin
        col_n = set_pos_x;
        page_n = set_pos_y;
        rem_n = burst_len;
        err_n = ({1'b0, set_pos_x} >= cols_w) || (set_pos_y > last_page);
        state_n = (err_n || burst_len == '0) ? DONE : CMD_PAGE;
      end
      CMD_PAGE: if (send_done) begin
        state_n = GAP;
        ret_n = CMD_COLH;
      end
      CMD_COLH: if (send_done) begin
        state_n = GAP;
        ret_n = CMD_COLL;
      end
      CMD_COLL: if (send_done) begin
        state_n = GAP;
        ret_n = DATA_WAIT;
      end
      DATA_WAIT: if (data_valid) begin
        state_n = DATA_SEND;
        data_n = data_in;
      end
      DATA_SEND: if (send_done) begin
        state_n = GAP;
        rem_n = rem - LEN_W'(1);
        col_n = (col == last_col) ? 8'd0 : col + 8'd1;
        page_n = (col != last_col) ? page : (page == last_page) ? 8'd0 : page + 8'd1;
        ret_n = (rem == LEN_W'(1)) ? DONE : (col == last_col) ? CMD_PAGE : DATA_WAIT;
      end
      GAP: state_n = ret;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so a send state drives spi_send from its first cycle.
  assign sending = (state_n == CMD_PAGE) || (state_n == CMD_COLH) || (state_n == CMD_COLL) || (state_n == DATA_SEND);
  assign cv = col_n + col_off;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ret <= IDLE;
      col <= '0;
      page <= '0;
      rem <= '0;
      data_q <= '0;
      err <= 1'b0;
      spi_send <= 1'b0;
      spi_data <= '0;
      dc <= 1'b0;
      data_ready <= 1'b0;
      busy <= 1'b0;
      write_done <= 1'b0;
      pos_err <= 1'b0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      col <= col_n;
      page <= page_n;
      rem <= rem_n;
      data_q <= data_n;
      err <= err_n;
      spi_send <= sending;
      if (sending) begin
        spi_data <= (state_n == CMD_PAGE) ? {5'b10110, page_n[2:0]} :
                    (state_n == CMD_COLH) ? {4'h1, cv[7:4]} :
                    (state_n == CMD_COLL) ? {4'h0, cv[3:0]} : data_n;
        dc <= (state_n == DATA_SEND);
      end
      data_ready <= (state == DATA_WAIT) && data_valid;
      busy <= (state_n != IDLE);
      write_done <= (state == DONE);
      pos_err <= (state == DONE) && err;
    end
  end
endmodule
